// File: rtl/share_encoder_rng.sv
// Two-share Boolean encoder with an internal 32-bit LFSR feeding a masked multiplier.
// Optional build macro SHARE_ENC_DBG_UNMASK_EN adds dbg_a/dbg_b with the unmasked operands.
module share_encoder_rng #(
  parameter int LANES      = 1,
  parameter int WARMUP_CYC = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          seed,
  input  logic                 seed_valid,
  input  logic [LANES-1:0]     in_a,
  input  logic [LANES-1:0]     in_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*LANES-1:0]   port_a,
  output logic [2*LANES-1:0]   port_b,
  output logic [LANES-1:0]     port_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rng_ok
`ifdef SHARE_ENC_DBG_UNMASK_EN
  ,
  output logic [LANES-1:0]     dbg_a,
  output logic [LANES-1:0]     dbg_b
`endif
);

  localparam int K = 3 * LANES;
  localparam logic [7:0] LAST_CNT = 8'(WARMUP_CYC - 1);

  typedef enum logic [1:0] {S_NOSEED = 2'd0, S_WARMUP = 2'd1, S_RUN = 2'd2} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid holds with stable data until out_ready, in_ready only rises in RUN.
  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_lfsr;
  logic [7:0]          r_cnt;
  logic [2*LANES-1:0]  r_port_a;
  logic [2*LANES-1:0]  r_port_b;
  logic [LANES-1:0]    r_port_r;
  logic                r_out_valid;
  logic                w_in_ready;
  logic                w_rng_ok;
  logic                w_accept;
  logic [31:0]         w_adv;
  logic [31:0]         w_seed_load;
  logic [2*LANES-1:0]  w_pa;
  logic [2*LANES-1:0]  w_pb;
  logic [LANES-1:0]    w_pr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_NOSEED;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NOSEED: if (seed_valid) w_state_nxt = S_WARMUP;
      S_WARMUP: begin
        if (seed_valid)             w_state_nxt = S_WARMUP;
        else if (r_cnt == LAST_CNT) w_state_nxt = S_RUN;
      end
      S_RUN:    if (seed_valid) w_state_nxt = S_WARMUP;
      default:  w_state_nxt = S_NOSEED;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_in_ready = 1'b0;
    w_rng_ok   = 1'b0;
    case (r_state)
      S_RUN: begin
        w_rng_ok   = 1'b1;
        w_in_ready = !r_out_valid || out_ready;
      end
      default: ;
    endcase
  end

  // A reseed in the same cycle wins over the operands.
  assign w_accept    = w_in_ready && in_valid && !seed_valid;
  assign w_seed_load = (seed == 32'h0) ? 32'h1 : seed;

  // K unrolled steps per accept; the low K bits become masks and gadget randomness.
  always_comb begin
    w_adv = r_lfsr;
    for (int k = 0; k < K; k++) w_adv = lfsr_step(w_adv);
  end

  always_comb begin
    w_pa = '0;
    w_pb = '0;
    w_pr = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pa[2*i]   = in_a[i] ^ w_adv[i];
      w_pa[2*i+1] = w_adv[i];
      w_pb[2*i]   = in_b[i] ^ w_adv[LANES+i];
      w_pb[2*i+1] = w_adv[LANES+i];
      w_pr[i]     = w_adv[2*LANES+i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 32'h1;
      r_cnt  <= 8'd0;
    end else if (seed_valid) begin
      r_lfsr <= w_seed_load;
      r_cnt  <= 8'd0;
    end else if (r_state == S_WARMUP) begin
      r_lfsr <= lfsr_step(r_lfsr);
      r_cnt  <= r_cnt + 8'd1;
    end else if (w_accept) begin
      r_lfsr <= w_adv;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_port_a    <= '0;
      r_port_b    <= '0;
      r_port_r    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_port_a    <= w_pa;
      r_port_b    <= w_pb;
      r_port_r    <= w_pr;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef SHARE_ENC_DBG_UNMASK_EN
  logic [LANES-1:0] r_dbg_a;
  logic [LANES-1:0] r_dbg_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dbg_a <= '0;
      r_dbg_b <= '0;
    end else if (w_accept) begin
      r_dbg_a <= in_a;
      r_dbg_b <= in_b;
    end
  end

  assign dbg_a = r_dbg_a;
  assign dbg_b = r_dbg_b;
`endif

  assign in_ready  = w_in_ready;
  assign rng_ok    = w_rng_ok;
  assign out_valid = r_out_valid;
  assign port_a    = r_port_a;
  assign port_b    = r_port_b;
  assign port_r    = r_port_r;

endmodule

// File: tb/tb_share_encoder_rng.sv
// Bench for share_encoder_rng: directed steps plus random traffic against a cycle model
// that replays the LFSR in software and scores every delivered encoding.
module tb_share_encoder_rng;

  localparam int LANES      = 1;
  localparam int WARMUP_CYC = 32;
  localparam int K          = 3 * LANES;
  localparam int EW         = 5 * LANES;

  logic                clk;
  logic                reset;
  logic [31:0]         seed;
  logic                seed_valid;
  logic [LANES-1:0]    in_a;
  logic [LANES-1:0]    in_b;
  logic                in_valid;
  logic                in_ready;
  logic [2*LANES-1:0]  port_a;
  logic [2*LANES-1:0]  port_b;
  logic [LANES-1:0]    port_r;
  logic                out_valid;
  logic                out_ready;
  logic                rng_ok;
`ifdef SHARE_ENC_DBG_UNMASK_EN
  logic [LANES-1:0]    dbg_a;
  logic [LANES-1:0]    dbg_b;
`endif

  share_encoder_rng #(.LANES(LANES), .WARMUP_CYC(WARMUP_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .seed_valid (seed_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .port_a     (port_a),
    .port_b     (port_b),
    .port_r     (port_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rng_ok     (rng_ok)
`ifdef SHARE_ENC_DBG_UNMASK_EN
    ,
    .dbg_a      (dbg_a),
    .dbg_b      (dbg_b)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = no seed, 1 = warming up, 2 = running.
  int                  m_phase = 0;
  int                  m_cnt   = 0;
  logic [31:0]         m_s     = 32'h1;
  bit                  m_ov    = 1'b0;
  logic [2*LANES-1:0]  m_pa    = '0;
  logic [2*LANES-1:0]  m_pb    = '0;
  logic [LANES-1:0]    m_pr    = '0;
  logic [LANES-1:0]    m_da    = '0;
  logic [LANES-1:0]    m_db    = '0;
  logic [EW-1:0]       exp_q[$];

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic fb;
    fb = ^(s & 32'h8020_0003);
    return (s << 1) | {31'b0, fb};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle with the given inputs, model update and checks on both sides of the edge.
  task automatic cyc(input bit rst, input bit sv, input logic [31:0] sd, input bit iv,
                     input logic [LANES-1:0] a, input logic [LANES-1:0] b, input bit ordy);
    bit            exp_rdy;
    bit            accept;
    bit            consume;
    logic [31:0]   w;
    logic [EW-1:0] e;
    reset = rst; seed_valid = sv; seed = sd; in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
    #1;
    exp_rdy = (m_phase == 2) && (!m_ov || ordy);
    consume = m_ov && ordy;
    accept  = exp_rdy && iv && !sv && !rst;
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (consume) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("delivered", 64'({port_a, port_b, port_r}), 64'(e));
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_s = 32'h1; m_ov = 1'b0;
      m_pa = '0; m_pb = '0; m_pr = '0; m_da = '0; m_db = '0;
      exp_q.delete();
    end else begin
      if (sv) begin
        m_s = (sd == 0) ? 32'h1 : sd;
        m_cnt = 0;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_s = m_step(m_s);
        m_cnt++;
        if (m_cnt == WARMUP_CYC) m_phase = 2;
      end else if (accept) begin
        for (int k = 0; k < K; k++) m_s = m_step(m_s);
        w = m_s;
        for (int i = 0; i < LANES; i++) begin
          m_pa[2*i+1] = w[i];
          m_pa[2*i]   = a[i] ^ w[i];
          m_pb[2*i+1] = w[LANES+i];
          m_pb[2*i]   = b[i] ^ w[LANES+i];
          m_pr[i]     = w[2*LANES+i];
        end
        m_da = a; m_db = b;
        exp_q.push_back({m_pa, m_pb, m_pr});
      end
      if (accept) m_ov = 1'b1;
      else if (consume) m_ov = 1'b0;
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("rng_ok", 64'(rng_ok), 64'(m_phase == 2));
    chk("port_a", 64'(port_a), 64'(m_pa));
    chk("port_b", 64'(port_b), 64'(m_pb));
    chk("port_r", 64'(port_r), 64'(m_pr));
`ifdef SHARE_ENC_DBG_UNMASK_EN
    chk("dbg_a", 64'(dbg_a), 64'(m_da));
    chk("dbg_b", 64'(dbg_b), 64'(m_db));
`endif
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        chk("share_a_xor", 64'(port_a[2*i] ^ port_a[2*i+1]), 64'(a[i]));
        chk("share_b_xor", 64'(port_b[2*i] ^ port_b[2*i+1]), 64'(b[i]));
      end
    end
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, '0, '0, ordy);
  endtask

  task automatic reseed(input logic [31:0] sd);
    cyc(1'b0, 1'b1, sd, 1'b0, '0, '0, 1'b1);
    repeat (WARMUP_CYC) idle(1'b1);
  endtask

  task automatic send(input logic [LANES-1:0] a, input logic [LANES-1:0] b, input bit ordy);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, a, b, ordy);
  endtask

  initial begin
    int n;
    reset = 1'b1; seed = '0; seed_valid = 1'b0; in_a = '0; in_b = '0;
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset, then no seed with operands offered for 50 cycles
    cyc(1'b1, 1'b0, 32'h0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, '1, '1, 1'b1);

    // Zero seed: warmup length and LFSR start from 1
    cyc(1'b0, 1'b1, 32'h0, 1'b0, '0, '0, 1'b1);
    n = 0;
    while (rng_ok !== 1'b1 && n < 100) begin
      idle(1'b1);
      n++;
    end
    chk("warmup_len", 64'(n), 64'(WARMUP_CYC));
    send(1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Seed ACE1, all operand combinations back to back
    reseed(32'hACE1);
    for (int c = 0; c < 4; c++) send(LANES'(c & 1), LANES'(c >> 1), 1'b1);
    idle(1'b1);

    // Backpressure: second operand held for 10 cycles, then accepted
    reseed(32'h1234_5678);
    send(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    chk("stall_accept", 64'(out_valid), 64'(1));
    idle(1'b1);

    // Reseed collides with operands while an output is pending
    send(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reseed_pending_valid", 64'(out_valid), 64'(1));
    idle(1'b1);
    chk("reseed_pending_drained", 64'(out_valid), 64'(0));
    repeat (WARMUP_CYC) idle(1'b1);

    // Reset mid-warmup and mid-stream
    cyc(1'b0, 1'b1, 32'h5555_0001, 1'b0, '0, '0, 1'b1);
    repeat (5) idle(1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, '1, '1, 1'b1);
    reseed(32'h0BAD_F00D);
    send(1'b1, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, '1, '1, 1'b0);
    idle(1'b1);

    // Random traffic with stalls and occasional reseeds
    reseed(32'hC0FF_EE11);
    for (int i = 0; i < 600; i++) begin
      bit          sv;
      logic [31:0] sd;
      sv = ($urandom_range(0, 99) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      cyc(1'b0, sv, sd, ($urandom_range(0, 3) != 0), LANES'($urandom()), LANES'($urandom()),
          ($urandom_range(0, 3) != 0));
    end
    repeat (4) idle(1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
